// File: rtl/level_pkg.sv
// ============================================================================
// Module      : level_pkg
// Description : Shared tile codes, colour constants, map geometry and
//               pixel-pattern helpers for the level renderer and level logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package level_pkg;

    localparam int MAP_W           = 17;
    localparam int MAP_H           = 12;
    localparam int CHARACTER_WIDTH = 42;
    localparam int SCREEN_WIDTH    = 640;
    localparam int SCREEN_HEIGHT   = 480;
    localparam int BLOCK_WIDTH     = 40;
    localparam int TILES_X         = SCREEN_WIDTH / BLOCK_WIDTH;
    localparam int TILES_Y         = SCREEN_HEIGHT / BLOCK_WIDTH;

    localparam logic [7:0] BDR = 8'd0;
    localparam logic [7:0] SKY = 8'd1;
    localparam logic [7:0] BLK = 8'd2;
    localparam logic [7:0] GND = 8'd3;
    localparam logic [7:0] TKN = 8'd4;
    localparam logic [7:0] CK1 = 8'd5;
    localparam logic [7:0] CK2 = 8'd6;

    typedef logic [MAP_H-1:0][MAP_W-1:0][7:0] tile_map_t;
    typedef logic [4:0] tile_x_t;
    typedef logic [3:0] tile_y_t;
    typedef logic [5:0] tile_px_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t COL_BLACK   = rgb12_t'(12'h000);
    localparam rgb12_t COL_WHITE   = rgb12_t'(12'hFFF);
    localparam rgb12_t COL_MARIO   = rgb12_t'(12'hF00);
    localparam rgb12_t COL_GOOMBA  = rgb12_t'(12'h840);
    localparam rgb12_t COL_SKY     = rgb12_t'(12'h6AF);
    localparam rgb12_t COL_GROUND  = rgb12_t'(12'h841);
    localparam rgb12_t COL_BRICK   = rgb12_t'(12'hC41);
    localparam rgb12_t COL_MORTAR  = rgb12_t'(12'h888);
    localparam rgb12_t COL_COIN    = rgb12_t'(12'hFD0);
    localparam rgb12_t COL_MAGENTA = rgb12_t'(12'hF0F);

    // 33-bit signed compares so a box near the int limit cannot wrap into view.
    function automatic logic sprite_hit(input int col, input int row,
                                        input int sx,  input int sy);
        logic signed [32:0] c33, r33, x33, y33, w33;
        c33 = 33'(col);
        r33 = 33'(row);
        x33 = 33'(sx);
        y33 = 33'(sy);
        w33 = 33'(CHARACTER_WIDTH);
        return (c33 >= x33) && (c33 < x33 + w33) &&
               (r33 >= y33) && (r33 < y33 + w33);
    endfunction

    function automatic rgb12_t tile_colour(input logic [7:0] code,
                                           input tile_px_t px,
                                           input tile_px_t py);
        rgb12_t     c;
        logic [6:0] dx;
        logic [6:0] dy;
        logic       dark;
        dx   = (px >= 6'd20) ? 7'(px - 6'd20) : 7'(6'd20 - px);
        dy   = (py >= 6'd20) ? 7'(py - 6'd20) : 7'(6'd20 - py);
        dark = px[3] ^ py[3] ^ (code == CK2);
        case (code)
            BDR: c = COL_BLACK;
            SKY: c = COL_SKY;
            GND: c = COL_GROUND;
            BLK: begin
                // Running bond: vertical joints offset by half a brick per course.
                if ((py == 6'd0) || (py == 6'd20) ||
                    ((py < 6'd20) && (px == 6'd0)) ||
                    ((py >= 6'd20) && (px == 6'd20)))
                    c = COL_MORTAR;
                else
                    c = COL_BRICK;
            end
            TKN:      c = ((dx + dy) <= 7'd14) ? COL_COIN : COL_SKY;
            CK1, CK2: c = dark ? COL_BLACK : COL_WHITE;
            default:  c = COL_MAGENTA;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_to_tile.sv
// ============================================================================
// Module      : pixel_to_tile
// Description : Combinational raster-to-tile mapping (tile index and offset)
//               using a constant-compare chain instead of a divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_to_tile
    import level_pkg::*;
(
    input  int       column,
    input  int       row,
    output tile_x_t  tile_x,
    output tile_y_t  tile_y,
    output tile_px_t pixel_x,
    output tile_px_t pixel_y
);

    // Outputs are meaningful only for on-screen coordinates.
    always_comb begin
        tile_x = '0;
        for (int i = 1; i < TILES_X; i++) begin
            if (column >= i * BLOCK_WIDTH) tile_x = tile_x_t'(i);
        end
        tile_y = '0;
        for (int j = 1; j < TILES_Y; j++) begin
            if (row >= j * BLOCK_WIDTH) tile_y = tile_y_t'(j);
        end
        pixel_x = tile_px_t'(column - int'(tile_x) * BLOCK_WIDTH);
        pixel_y = tile_px_t'(row - int'(tile_y) * BLOCK_WIDTH);
    end

endmodule

`default_nettype wire

// File: rtl/tile_pixel_renderer.sv
// ============================================================================
// Module      : tile_pixel_renderer
// Description : Three-stage pixel pipeline: tile lookup in the live level map,
//               per-tile pattern, Mario/Goomba overlay, VGA colour out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_pixel_renderer
    import level_pkg::*;
(
    input  logic       vga_clock,
    input  logic       reset,
    input  int         row,
    input  int         column,
    input  logic       display_enable,
    input  tile_map_t  background,
    input  int         mario_x,
    input  int         mario_y,
    input  int         goomba_x,
    input  int         goomba_y,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue,
    output logic       pixel_valid,
    output logic [7:0] tile_code
);

    tile_x_t  w_tile_x;
    tile_y_t  w_tile_y;
    tile_px_t w_px;
    tile_px_t w_py;
    logic     w_in_range;
    logic     w_mario_hit;
    logic     w_goomba_hit;

    pixel_to_tile u_pixel_to_tile (
        .column  (column),
        .row     (row),
        .tile_x  (w_tile_x),
        .tile_y  (w_tile_y),
        .pixel_x (w_px),
        .pixel_y (w_py)
    );

    assign w_in_range   = display_enable &&
                          (column >= 0) && (column < SCREEN_WIDTH) &&
                          (row >= 0)    && (row < SCREEN_HEIGHT);
    assign w_mario_hit  = sprite_hit(column, row, mario_x, mario_y);
    assign w_goomba_hit = sprite_hit(column, row, goomba_x, goomba_y);

    // Stage 1: coordinates. The map is stored mirrored, so screen top-left is [MAP_H-1][MAP_W-1].
    logic     r1_valid;
    tile_x_t  r1_x_idx;
    tile_y_t  r1_y_idx;
    tile_px_t r1_px;
    tile_px_t r1_py;
    logic     r1_mario;
    logic     r1_goomba;

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r1_valid  <= 1'b0;
            r1_x_idx  <= '0;
            r1_y_idx  <= '0;
            r1_px     <= '0;
            r1_py     <= '0;
            r1_mario  <= 1'b0;
            r1_goomba <= 1'b0;
        end else begin
            r1_valid  <= w_in_range;
            r1_x_idx  <= tile_x_t'(MAP_W - 1) - w_tile_x;
            r1_y_idx  <= tile_y_t'(MAP_H - 1) - w_tile_y;
            r1_px     <= w_px;
            r1_py     <= w_py;
            r1_mario  <= w_mario_hit;
            r1_goomba <= w_goomba_hit;
        end
    end

    // Stage 2: live map fetch.
    logic [7:0] w_code;
    assign w_code = r1_valid ? background[r1_y_idx][r1_x_idx] : BDR;

    logic       r2_valid;
    logic [7:0] r2_code;
    tile_px_t   r2_px;
    tile_px_t   r2_py;
    logic       r2_mario;
    logic       r2_goomba;

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r2_valid  <= 1'b0;
            r2_code   <= BDR;
            r2_px     <= '0;
            r2_py     <= '0;
            r2_mario  <= 1'b0;
            r2_goomba <= 1'b0;
        end else begin
            r2_valid  <= r1_valid;
            r2_code   <= w_code;
            r2_px     <= r1_px;
            r2_py     <= r1_py;
            r2_mario  <= r1_mario;
            r2_goomba <= r1_goomba;
        end
    end

    // Stage 3: colour with sprite priority over the tile pattern.
    rgb12_t w_colour;

    always_comb begin
        w_colour = COL_BLACK;
        if (!r2_valid)
            w_colour = COL_BLACK;
        else if (r2_mario)
            w_colour = COL_MARIO;
        else if (r2_goomba)
            w_colour = COL_GOOMBA;
        else
            w_colour = tile_colour(r2_code, r2_px, r2_py);
    end

    rgb12_t     r3_colour;
    logic       r3_valid;
    logic [7:0] r3_code;

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r3_colour <= COL_BLACK;
            r3_valid  <= 1'b0;
            r3_code   <= BDR;
        end else begin
            r3_colour <= w_colour;
            r3_valid  <= r2_valid;
            r3_code   <= r2_code;
        end
    end

    assign vga_red     = r3_colour.r;
    assign vga_green   = r3_colour.g;
    assign vga_blue    = r3_colour.b;
    assign pixel_valid = r3_valid;
    assign tile_code   = r3_code;

endmodule

`default_nettype wire

// File: tb/tb_tile_pixel_renderer.sv
// ============================================================================
// Module      : tb_tile_pixel_renderer
// Description : Directed self-checking bench for tile_pixel_renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_pixel_renderer;
    import level_pkg::*;

    logic       vga_clock = 1'b0;
    logic       reset     = 1'b1;
    int         row       = 0;
    int         column    = 0;
    logic       display_enable = 1'b0;
    tile_map_t  background;
    int         mario_x   = -1000;
    int         mario_y   = -1000;
    int         goomba_x  = -1000;
    int         goomba_y  = -1000;
    logic [3:0] vga_red;
    logic [3:0] vga_green;
    logic [3:0] vga_blue;
    logic       pixel_valid;
    logic [7:0] tile_code;

    int n_compared   = 0;
    int n_mismatched = 0;

    wire [12:0] obs = {pixel_valid, vga_red, vga_green, vga_blue};

    always #5 vga_clock = ~vga_clock;

    tile_pixel_renderer dut (
        .vga_clock      (vga_clock),
        .reset          (reset),
        .row            (row),
        .column         (column),
        .display_enable (display_enable),
        .background     (background),
        .mario_x        (mario_x),
        .mario_y        (mario_y),
        .goomba_x       (goomba_x),
        .goomba_y       (goomba_y),
        .vga_red        (vga_red),
        .vga_green      (vga_green),
        .vga_blue       (vga_blue),
        .pixel_valid    (pixel_valid),
        .tile_code      (tile_code)
    );

    task automatic drive(input int r, input int c, input logic de);
        @(negedge vga_clock);
        row = r;
        column = c;
        display_enable = de;
    endtask

    task automatic settle3;
        repeat (3) @(posedge vga_clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; row = 0; column = 0; display_enable = 1'b1;
        repeat (2) @(posedge vga_clock);
        #1;
        n_compared++;
        if ({obs, tile_code} !== 21'h0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got %h/%h want 0000/00", obs, tile_code);
        end
        @(negedge vga_clock);
        reset = 1'b0; row = 440; column = 200;
        settle3;
        n_compared++;
        if (obs !== 13'h16AF) begin
            n_mismatched++;
            $display("FAIL prefill_sky: got %h want 16af", obs);
        end
        @(negedge vga_clock);
        reset = 1'b1; row = 0; column = 0;
        @(posedge vga_clock);
        #1;
        n_compared++;
        if ({obs, tile_code} !== 21'h0) begin
            n_mismatched++;
            $display("FAIL reset_flush: got %h/%h want 0000/00", obs, tile_code);
        end
        @(posedge vga_clock);
        @(negedge vga_clock);
        reset = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge vga_clock);
            #1;
            n_compared++;
            if (obs !== 13'h0000) begin
                n_mismatched++;
                $display("FAIL post_reset_%0d: got %h want 0000", k, obs);
            end
        end
        @(posedge vga_clock);
        #1;
        n_compared++;
        if ({obs, tile_code} !== {13'h1000, BDR}) begin
            n_mismatched++;
            $display("FAIL first_valid_bdr: got %h/%h want 1000/00", obs, tile_code);
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] exp_seq [4];
        exp_seq = '{13'h1841, 13'h1841, 13'h1841, 13'h0000};
        @(negedge vga_clock); row = 60; column = 20; display_enable = 1'b1;
        @(negedge vga_clock); column = 21;
        @(negedge vga_clock); column = 22;
        @(posedge vga_clock);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_compared++;
            if (obs !== exp_seq[k]) begin
                n_mismatched++;
                $display("FAIL stream_%0d: got %h want %h", k, obs, exp_seq[k]);
            end
            @(negedge vga_clock);
            display_enable = 1'b0;
            @(posedge vga_clock);
        end
        display_enable = 1'b1;
    endtask

    task automatic test_coin_and_write;
        drive(220, 420, 1'b1); settle3;
        n_compared++;
        if ({obs, tile_code} !== {13'h1FD0, TKN}) begin
            n_mismatched++;
            $display("FAIL coin_centre: got %h/%h want 1fd0/04", obs, tile_code);
        end
        drive(200, 400, 1'b1); settle3;
        n_compared++;
        if (obs !== 13'h16AF) begin
            n_mismatched++;
            $display("FAIL coin_corner: got %h want 16af", obs);
        end
        drive(220, 434, 1'b1); settle3;
        n_compared++;
        if (obs !== 13'h1FD0) begin
            n_mismatched++;
            $display("FAIL coin_edge_in: got %h want 1fd0", obs);
        end
        drive(220, 435, 1'b1); settle3;
        n_compared++;
        if (obs !== 13'h16AF) begin
            n_mismatched++;
            $display("FAIL coin_edge_out: got %h want 16af", obs);
        end
        @(negedge vga_clock);
        background[6][6] = SKY;
        drive(220, 420, 1'b1); settle3;
        n_compared++;
        if ({obs, tile_code} !== {13'h16AF, SKY}) begin
            n_mismatched++;
            $display("FAIL coin_cleared: got %h/%h want 16af/01", obs, tile_code);
        end
    endtask

    task automatic test_sprites;
        mario_x = 400; mario_y = 200; goomba_x = 420; goomba_y = 220;
        drive(230, 430, 1'b1); settle3;
        n_compared++;
        if (obs !== 13'h1F00) begin
            n_mismatched++;
            $display("FAIL mario_over_goomba: got %h want 1f00", obs);
        end
        drive(255, 450, 1'b1); settle3;
        n_compared++;
        if (obs !== 13'h1840) begin
            n_mismatched++;
            $display("FAIL goomba_only: got %h want 1840", obs);
        end
        drive(199, 430, 1'b1); settle3;
        n_compared++;
        if (obs !== 13'h1841) begin
            n_mismatched++;
            $display("FAIL above_mario: got %h want 1841", obs);
        end
        mario_x = -30; mario_y = -30;
        drive(5, 5, 1'b1); settle3;
        n_compared++;
        if (obs !== 13'h1F00) begin
            n_mismatched++;
            $display("FAIL mario_clipped: got %h want 1f00", obs);
        end
        drive(12, 5, 1'b1); settle3;
        n_compared++;
        if (obs !== 13'h1000) begin
            n_mismatched++;
            $display("FAIL mario_box_end: got %h want 1000", obs);
        end
        mario_x = -1000; mario_y = -1000; goomba_x = -1000; goomba_y = -1000;
    endtask

    task automatic test_out_of_range;
        int          vr [5];
        int          vc [5];
        logic        vd [5];
        logic [12:0] ve [5];
        vr = '{100, 100, 480, 100, 479};
        vc = '{100, 640, 100, 639, 100};
        vd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ve = '{13'h0000, 13'h0000, 13'h0000, 13'h16AF, 13'h1FFF};
        for (int k = 0; k < 5; k++) begin
            drive(vr[k], vc[k], vd[k]); settle3;
            n_compared++;
            if (obs !== ve[k]) begin
                n_mismatched++;
                $display("FAIL range_%0d (r%0d c%0d de%0b): got %h want %h",
                         k, vr[k], vc[k], vd[k], obs, ve[k]);
            end
            if (k < 3) begin
                n_compared++;
                if (tile_code !== BDR) begin
                    n_mismatched++;
                    $display("FAIL range_code_%0d: got %h want 00", k, tile_code);
                end
            end
        end
    endtask

    task automatic test_error_code;
        drive(250, 250, 1'b1); settle3;
        n_compared++;
        if ({obs, tile_code} !== {13'h1F0F, 8'd9}) begin
            n_mismatched++;
            $display("FAIL unknown_code: got %h/%h want 1f0f/09", obs, tile_code);
        end
    endtask

    task automatic test_checker;
        int          vr [5];
        int          vc [5];
        logic [12:0] ve [5];
        vr = '{440, 440, 440, 448, 448};
        vc = '{40, 48, 80, 88, 80};
        ve = '{13'h1000, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1000};
        for (int k = 0; k < 5; k++) begin
            drive(vr[k], vc[k], 1'b1); settle3;
            n_compared++;
            if (obs !== ve[k]) begin
                n_mismatched++;
                $display("FAIL checker_%0d (r%0d c%0d): got %h want %h",
                         k, vr[k], vc[k], obs, ve[k]);
            end
        end
    endtask

    task automatic test_brick;
        int          vr [7];
        int          vc [7];
        logic [12:0] ve [7];
        vr = '{85, 80, 85, 85, 105, 105, 100};
        vc = '{85, 85, 80, 100, 100, 80, 85};
        ve = '{13'h1C41, 13'h1888, 13'h1888, 13'h1C41, 13'h1888, 13'h1C41, 13'h1888};
        for (int k = 0; k < 7; k++) begin
            drive(vr[k], vc[k], 1'b1); settle3;
            n_compared++;
            if (obs !== ve[k]) begin
                n_mismatched++;
                $display("FAIL brick_%0d (r%0d c%0d): got %h want %h",
                         k, vr[k], vc[k], obs, ve[k]);
            end
        end
    endtask

    initial begin
        for (int y = 0; y < MAP_H; y++)
            for (int x = 0; x < MAP_W; x++)
                background[y][x] = SKY;
        background[11][16] = BDR;
        background[10][16] = GND;
        background[7][6]   = GND;
        background[6][6]   = TKN;
        background[5][10]  = 8'd9;
        background[0][15]  = CK2;
        background[0][14]  = CK1;
        background[9][14]  = BLK;

        test_reset;
        test_back_to_back;
        test_coin_and_write;
        test_sprites;
        test_out_of_range;
        test_error_code;
        test_checker;
        test_brick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
